alu_iter: RTL and testbench

- Execution-stage ALU that consumes the 4-bit ALU control code from the ALU decoder, plus two operands.
- Produces a registered result and branch flags through valid/ready handshakes.
- Arithmetic and logic ops complete in one cycle. Shifts run iteratively, one bit per cycle, so no barrel shifter is needed.
- Sits between the decode/operand-select stage and the writeback/branch-resolve logic.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_core_comb.sv | 61 ++++++
 rtl/alu_iter.sv | 163 ++++++++++++++++
 tb/tb_alu_iter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : ALU control codes, iterative-ALU FSM states and code helpers.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    // Shared with the ALU decoder; unlisted codes are illegal.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0111,
        ALU_SLL  = 4'b1000,
        ALU_SRL  = 4'b1001,
        ALU_SRA  = 4'b1011
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core_comb.sv
`default_nettype none
// ============================================================================
//  Module   : alu_core_comb
//  Purpose  : Single-cycle ALU operations; shift codes pass operand A through.
//  Revision : 1.0  initial release
// ============================================================================
module alu_core_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    localparam logic [WIDTH:0] c_one = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;
    logic           w_slt;
    logic           w_sltu;

    // Subtraction as a + ~b + 1 so the carry-out is the no-borrow flag.
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} + {1'b0, ~b} + c_one;
    assign w_slt  = $signed(a) < $signed(b);
    assign w_sltu = a < b;

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (code)
            ALU_ADD: begin
                result   = w_sum[WIDTH-1:0];
                carry    = w_sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result   = w_diff[WIDTH-1:0];
                carry    = w_diff[WIDTH];
                overflow = (a[WIDTH-1] == ~b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, w_slt};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, w_sltu};
            ALU_SLL, ALU_SRL, ALU_SRA: result = a;
            default:  illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_iter
//  Purpose  : Handshaked execution ALU; shifts iterate one bit per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal_op
);

    localparam logic [SHAMT_W-1:0] c_cnt_one = {{(SHAMT_W-1){1'b0}}, 1'b1};

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_acc;
    logic [SHAMT_W-1:0] r_cnt;
    logic [3:0]         r_code;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_negative;
    logic               r_carry;
    logic               r_overflow;
    logic               r_illegal;

    logic [WIDTH-1:0]   w_core_result;
    logic               w_core_carry;
    logic               w_core_overflow;
    logic               w_core_illegal;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_accept;
    logic               w_shift_start;
    logic               w_shift_last;
    logic [WIDTH-1:0]   w_acc_shifted;

    alu_core_comb #(
        .WIDTH (WIDTH)
    ) u_core (
        .code     (alu_control),
        .a        (op_a),
        .b        (op_b),
        .result   (w_core_result),
        .carry    (w_core_carry),
        .overflow (w_core_overflow),
        .illegal  (w_core_illegal)
    );

    assign w_shamt       = op_b[SHAMT_W-1:0];
    assign w_accept      = in_valid && (r_state == IDLE);
    assign w_shift_start = is_shift(alu_control) && (w_shamt != '0);
    assign w_shift_last  = (r_state == SHIFT) && (r_cnt == c_cnt_one);

    always_comb begin
        w_acc_shifted = r_acc;
        case (r_code)
            ALU_SLL: w_acc_shifted = {r_acc[WIDTH-2:0], 1'b0};
            ALU_SRL: w_acc_shifted = {1'b0, r_acc[WIDTH-1:1]};
            ALU_SRA: w_acc_shifted = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
            default: w_acc_shifted = r_acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = w_shift_start ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (w_shift_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Result and flags only change at accept or on the last shift step,
    // so they hold stable for as long as DONE is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_code     <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_accept) begin
            if (w_shift_start) begin
                r_acc  <= op_a;
                r_cnt  <= w_shamt;
                r_code <= alu_control;
            end else begin
                r_result   <= w_core_result;
                r_zero     <= (w_core_result == '0);
                r_negative <= w_core_result[WIDTH-1];
                r_carry    <= w_core_carry;
                r_overflow <= w_core_overflow;
                r_illegal  <= w_core_illegal;
            end
        end else if (r_state == SHIFT) begin
            r_acc <= w_acc_shifted;
            r_cnt <= r_cnt - c_cnt_one;
            if (w_shift_last) begin
                r_result   <= w_acc_shifted;
                r_zero     <= (w_acc_shifted == '0);
                r_negative <= w_acc_shifted[WIDTH-1];
                r_carry    <= 1'b0;
                r_overflow <= 1'b0;
                r_illegal  <= 1'b0;
            end
        end
    end

    assign result     = r_result;
    assign zero       = r_zero;
    assign negative   = r_negative;
    assign carry      = r_carry;
    assign overflow   = r_overflow;
    assign illegal_op = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_iter
//  Purpose  : Self-checking bench for alu_iter with an expected-result queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_iter;
    import alu_pkg::*;

    // Expected packing: {illegal_op, zero, negative, carry, overflow, result}
    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [36:0] expv;
        logic [7:0]  lat;
    } vec_t;

    localparam longint c_smax = 64'sd2147483647;
    localparam longint c_smin = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;
    logic        illegal_op;

    int          checks   = 0;
    int          failures = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    alu_iter #(
        .WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .negative    (negative),
        .carry       (carry),
        .overflow    (overflow),
        .illegal_op  (illegal_op)
    );

    function automatic logic [36:0] model(input logic [3:0] code, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        logic        c, v, ill;
        longint      sa, sb, s;
        r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (code)
            4'b0000: begin r = a + b; c = (r < a); s = sa + sb; v = (s > c_smax) || (s < c_smin); end
            4'b0001: begin r = a - b; c = (a >= b); s = sa - sb; v = (s > c_smax) || (s < c_smin); end
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a ^ b;
            4'b0101: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b0111: r = (a < b) ? 32'd1 : 32'd0;
            4'b1000: r = a << b[4:0];
            4'b1001: r = a >> b[4:0];
            4'b1011: r = $signed(a) >>> b[4:0];
            default: ill = 1'b1;
        endcase
        return {ill, (r == 32'd0), r[31], c, v, r};
    endfunction

    // Issues one op and waits for its output; obs/lat/rdy_hi go back to the caller.
    task automatic do_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                         output logic [36:0] obs, output int lat, output int rdy_hi);
        @(negedge clk);
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        alu_control = code;
        op_a        = a;
        op_b        = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        lat      = -1;
        rdy_hi   = 0;
        obs      = '0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (in_ready) rdy_hi++;
            if (out_valid) begin
                lat = k;
                obs = {illegal_op, zero, negative, carry, overflow, result};
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, illegal_op, zero, negative, carry, overflow, result} !== {2'b01, 5'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_hold: got ov=%b ir=%b flags=%b res=%h, want ov=0 ir=1 flags=0 res=0",
                     out_valid, in_ready, {illegal_op, zero, negative, carry, overflow}, result);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, result} !== {2'b01, 32'h0}) begin
            failures++;
            $display("FAIL reset_release: got ov=%b ir=%b res=%h, want ov=0 ir=1 res=0", out_valid, in_ready, result);
        end
    endtask

    task automatic test_arith();
        vec_t        v[7];
        logic [36:0] obs, expv;
        int          lat, rh;
        v[0] = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, {5'b00101, 32'h80000000}, 8'd1};
        v[1] = '{4'b0001, 32'h00000005, 32'h00000005, {5'b01010, 32'h00000000}, 8'd1};
        v[2] = '{4'b0001, 32'h00000003, 32'h00000005, {5'b00100, 32'hFFFFFFFE}, 8'd1};
        v[3] = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, {5'b01010, 32'h00000000}, 8'd1};
        v[4] = '{4'b0001, 32'h80000000, 32'h00000001, {5'b00011, 32'h7FFFFFFF}, 8'd1};
        v[5] = '{4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, {5'b00000, 32'h00F000F0}, 8'd1};
        v[6] = '{4'b0011, 32'hF0F0F0F0, 32'h0F0F0F0F, {5'b00100, 32'hFFFFFFFF}, 8'd1};
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(v[i].expv);
            do_op(v[i].code, v[i].a, v[i].b, obs, lat, rh);
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL arith[%0d] value: got %h, want %h", i, obs, expv);
            end
            checks++;
            if (lat != int'(v[i].lat)) begin
                failures++;
                $display("FAIL arith[%0d] latency: got %0d, want %0d", i, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_shift();
        vec_t        v[7];
        logic [36:0] obs, expv;
        int          lat, rh;
        v[0] = '{4'b1011, 32'h80000000, 32'h00000024, {5'b00100, 32'hF8000000}, 8'd5};
        v[1] = '{4'b1000, 32'h12345678, 32'h00000000, {5'b00000, 32'h12345678}, 8'd1};
        v[2] = '{4'b1000, 32'h00000001, 32'h0000001F, {5'b00100, 32'h80000000}, 8'd32};
        v[3] = '{4'b1001, 32'h80000000, 32'h0000003F, {5'b00000, 32'h00000001}, 8'd32};
        v[4] = '{4'b1001, 32'hF0000000, 32'h00000004, {5'b00000, 32'h0F000000}, 8'd5};
        v[5] = '{4'b1000, 32'h80000001, 32'h00000001, {5'b00000, 32'h00000002}, 8'd2};
        v[6] = '{4'b1011, 32'h7FFFFFFF, 32'h0000001F, {5'b01000, 32'h00000000}, 8'd32};
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(v[i].expv);
            do_op(v[i].code, v[i].a, v[i].b, obs, lat, rh);
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL shift[%0d] value: got %h, want %h", i, obs, expv);
            end
            checks++;
            if (lat != int'(v[i].lat)) begin
                failures++;
                $display("FAIL shift[%0d] latency: got %0d, want %0d", i, lat, v[i].lat);
            end
            checks++;
            if (rh != 0) begin
                failures++;
                $display("FAIL shift[%0d] in_ready_busy: high for %0d cycles, want 0", i, rh);
            end
        end
    endtask

    task automatic test_compare_illegal();
        vec_t        v[10];
        logic [36:0] obs, expv;
        int          lat, rh;
        v[0] = '{4'b0101, 32'hFFFFFFFF, 32'h00000001, {5'b00000, 32'h00000001}, 8'd1};
        v[1] = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, {5'b01000, 32'h00000000}, 8'd1};
        v[2] = '{4'b0101, 32'h00000001, 32'hFFFFFFFF, {5'b01000, 32'h00000000}, 8'd1};
        v[3] = '{4'b0111, 32'h00000001, 32'hFFFFFFFF, {5'b00000, 32'h00000001}, 8'd1};
        v[4] = '{4'b0110, 32'h00000005, 32'h00000007, {5'b11000, 32'h00000000}, 8'd1};
        v[5] = '{4'b1010, 32'h80000000, 32'h00000004, {5'b11000, 32'h00000000}, 8'd1};
        v[6] = '{4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, {5'b11000, 32'h00000000}, 8'd1};
        v[7] = '{4'b1101, 32'h7FFFFFFF, 32'h00000001, {5'b11000, 32'h00000000}, 8'd1};
        v[8] = '{4'b1110, 32'h12345678, 32'h00000003, {5'b11000, 32'h00000000}, 8'd1};
        v[9] = '{4'b1111, 32'hDEADBEEF, 32'h00000010, {5'b11000, 32'h00000000}, 8'd1};
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(v[i].expv);
            do_op(v[i].code, v[i].a, v[i].b, obs, lat, rh);
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv || lat != int'(v[i].lat)) begin
                failures++;
                $display("FAIL cmp_ill[%0d]: got %h lat %0d, want %h lat %0d", i, obs, lat, expv, v[i].lat);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  legal[10];
        logic [3:0]  code;
        logic [31:0] a, b;
        logic [36:0] obs, expv;
        int          lat, rh, want_lat;
        legal = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                  4'b0101, 4'b0111, 4'b1000, 4'b1001, 4'b1011};
        for (int i = 0; i < 24; i++) begin
            code = legal[$urandom_range(0, 9)];
            a    = $urandom;
            b    = $urandom;
            if (i % 4 == 0) b = a;
            want_lat = (code[3] && b[4:0] != 5'd0) ? int'(b[4:0]) + 1 : 1;
            exp_q.push_back(model(code, a, b));
            do_op(code, a, b, obs, lat, rh);
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv || lat != want_lat) begin
                failures++;
                $display("FAIL random[%0d] code=%b a=%h b=%h: got %h lat %0d, want %h lat %0d",
                         i, code, a, b, obs, lat, expv, want_lat);
            end
        end
    endtask

    task automatic test_hold();
        logic [36:0] obs, expv;
        int          lat;
        @(negedge clk);
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        alu_control = 4'b0001;
        op_a        = 32'd10;
        op_b        = 32'd3;
        exp_q.push_back({5'b00010, 32'h00000007});
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        obs = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                obs = {illegal_op, zero, negative, carry, overflow, result};
                break;
            end
        end
        expv = exp_q.pop_front();
        checks++;
        if (obs !== expv || lat != 1) begin
            failures++;
            $display("FAIL hold_first: got %h lat %0d, want %h lat 1", obs, lat, expv);
        end
        for (int i = 0; i < 3; i++) begin
            in_valid    = (i % 2 == 0);
            alu_control = 4'b0000;
            op_a        = $urandom;
            op_b        = $urandom;
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, illegal_op, zero, negative, carry, overflow, result} !== {2'b10, expv}) begin
                failures++;
                $display("FAIL hold_stall[%0d]: got ov=%b ir=%b val=%h, want ov=1 ir=0 val=%h", i, out_valid, in_ready,
                         {illegal_op, zero, negative, carry, overflow, result}, expv);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL hold_release: got ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL hold_no_phantom: got ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        int          spurious;
        logic [36:0] obs, expv;
        int          lat, rh;
        @(negedge clk);
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        alu_control = 4'b1000;
        op_a        = 32'h00000001;
        op_b        = 32'd20;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({out_valid, in_ready, illegal_op, zero, negative, carry, overflow, result} !== {2'b01, 5'b0, 32'h0}) begin
            failures++;
            $display("FAIL abort_state: got ov=%b ir=%b flags=%b res=%h, want ov=0 ir=1 flags=0 res=0",
                     out_valid, in_ready, {illegal_op, zero, negative, carry, overflow}, result);
        end
        spurious = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL abort_no_output: saw %0d out_valid cycles, want 0", spurious);
        end
        exp_q.push_back({5'b00000, 32'h00000014});
        do_op(4'b0000, 32'h0000000F, 32'h00000005, obs, lat, rh);
        expv = exp_q.pop_front();
        checks++;
        if (obs !== expv || lat != 1) begin
            failures++;
            $display("FAIL abort_recover: got %h lat %0d, want %h lat 1", obs, lat, expv);
        end
    endtask

    task automatic test_back_to_back();
        int          pulses, consec;
        logic        prev;
        logic [36:0] obs, expv;
        pulses = 0;
        consec = 0;
        prev   = 1'b0;
        @(negedge clk);
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        alu_control = 4'b0000;
        op_a        = 32'd1;
        op_b        = 32'd2;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) @(negedge clk);
            if (out_valid) begin
                pulses++;
                if (prev) consec++;
                obs  = {illegal_op, zero, negative, carry, overflow, result};
                expv = (exp_q.size() != 0) ? exp_q.pop_front() : 37'h1F_FFFF_FFFF;
                checks++;
                if (obs !== expv) begin
                    failures++;
                    $display("FAIL b2b_value[%0d]: got %h, want %h", k, obs, expv);
                end
            end
            prev = out_valid;
            if (k == 10) in_valid = 1'b0;
            else if (in_ready) exp_q.push_back({5'b00000, 32'h00000003});
        end
        checks++;
        if (pulses != 5 || consec != 0) begin
            failures++;
            $display("FAIL b2b_spacing: got %0d outputs %0d adjacent, want 5 outputs 0 adjacent", pulses, consec);
        end
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: got %0d pending ov=%b, want 0 pending ov=0", exp_q.size(), out_valid);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        alu_control = 4'b0000;
        op_a        = '0;
        op_b        = '0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        test_reset();
        test_arith();
        test_shift();
        test_compare_illegal();
        test_random();
        test_hold();
        test_reset_mid_shift();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
